// File: rtl/parking_pkg.sv
// Shared types for the two-beam parking sensor generator and detector.
// Holds the command and state encodings plus the phase-to-beam lookup.
package parking_pkg;

  typedef enum logic [1:0] {
    CmdEnter     = 2'd0,
    CmdExit      = 2'd1,
    CmdBalkEnter = 2'd2,
    CmdBalkExit  = 2'd3
  } cmd_e;

  typedef enum logic [5:0] {
    StIdle = 6'b000001,
    StPh1  = 6'b000010,
    StPh2  = 6'b000100,
    StPh3  = 6'b001000,
    StGap  = 6'b010000,
    StDone = 6'b100000
  } gen_state_e;

  typedef enum logic [1:0] {
    DetIdle = 2'd0,
    DetA    = 2'd1,
    DetAB   = 2'd2,
    DetB    = 2'd3
  } det_state_e;

  // Balk commands share bit 1; they stop after the first phase.
  function automatic logic is_balk(cmd_e c);
    return c[1];
  endfunction

  // Beam pair {a,b} driven while the generator sits in state s for command c.
  function automatic logic [1:0] phase_ab(cmd_e c, gen_state_e s);
    logic [1:0] ab;
    ab = 2'b00;
    case (s)
      StPh1:   ab = ((c == CmdEnter) || (c == CmdBalkEnter)) ? 2'b10 : 2'b01;
      StPh2:   ab = 2'b11;
      StPh3:   ab = (c == CmdEnter) ? 2'b01 : 2'b10;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter for phase and gap dwell: load N, then expire on the (N+1)th tick.
// Saturates at zero so a stray tick never wraps.
module phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  assign expire = tick && (count_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/parking_sensor_gen.sv
// Two-beam parking sensor waveform generator: one command per handshake,
// emitted as registered (a,b) phases with programmable dwell, then a settle gap.
module parking_sensor_gen
  import parking_pkg::*;
#(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               flush,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic               done_flush
);

  localparam logic [DWELL_W-1:0] GapLoad = DWELL_W'(MIN_GAP - 1);

  gen_state_e         state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic [DWELL_W-1:0] dwell_m1_q, dwell_m1_d;
  logic               flushed_q, flushed_d;

  logic               enter_phase;
  logic               enter_gap;
  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_value;
  logic               tmr_tick;
  logic               tmr_expire;

  logic [1:0]         ab_q;
  logic               busy_q;
  logic               done_q;
  logic               done_flush_q;
  logic               cmd_ready_q;

  assign tmr_tick = (state_q == StPh1) || (state_q == StPh2) ||
                    (state_q == StPh3) || (state_q == StGap);

  phase_timer #(
    .W (DWELL_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .value  (tmr_value),
    .tick   (tmr_tick),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    dwell_m1_d  = dwell_m1_q;
    flushed_d   = flushed_q;
    enter_phase = 1'b0;
    enter_gap   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && !flush) begin
          state_d     = StPh1;
          cmd_d       = cmd_e'(cmd);
          // A zero dwell is stretched to one cycle.
          dwell_m1_d  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          flushed_d   = 1'b0;
          enter_phase = 1'b1;
        end
      end
      StPh1: begin
        if (flush) begin
          flushed_d = 1'b1;
          enter_gap = 1'b1;
        end else if (tmr_expire) begin
          if (is_balk(cmd_q)) begin
            enter_gap = 1'b1;
          end else begin
            state_d     = StPh2;
            enter_phase = 1'b1;
          end
        end
      end
      StPh2: begin
        if (flush) begin
          flushed_d = 1'b1;
          enter_gap = 1'b1;
        end else if (tmr_expire) begin
          state_d     = StPh3;
          enter_phase = 1'b1;
        end
      end
      StPh3: begin
        if (flush) begin
          flushed_d = 1'b1;
          enter_gap = 1'b1;
        end else if (tmr_expire) begin
          enter_gap = 1'b1;
        end
      end
      StGap: begin
        if (tmr_expire) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (enter_gap) begin
      state_d = StGap;
    end

    tmr_load  = enter_phase || enter_gap;
    tmr_value = enter_gap ? GapLoad : dwell_m1_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cmd_q        <= CmdEnter;
      dwell_m1_q   <= '0;
      flushed_q    <= 1'b0;
      ab_q         <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_flush_q <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      dwell_m1_q   <= dwell_m1_d;
      flushed_q    <= flushed_d;
      // Outputs follow the next state so they change on the same edge as it.
      ab_q         <= phase_ab(cmd_d, state_d);
      busy_q       <= (state_d != StIdle);
      done_q       <= (state_d == StDone);
      done_flush_q <= (state_d == StDone) && flushed_d;
      cmd_ready_q  <= (state_d == StIdle);
    end
  end

  assign a          = ab_q[1];
  assign b          = ab_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_flush = done_flush_q;
  assign cmd_ready  = cmd_ready_q;

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Randomized bench for parking_sensor_gen against a waveform-schedule reference model.
// The model expands each accepted command into a queue of per-cycle expected outputs.
module tb_parking_sensor_gen;

  localparam int unsigned DWELL_W = 8;
  localparam int unsigned MIN_GAP = 2;

  logic               clk;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd;
  logic [DWELL_W-1:0] dwell;
  logic               flush;
  logic               a, b, busy, done, done_flush;

  parking_sensor_gen #(
    .DWELL_W (DWELL_W),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .dwell      (dwell),
    .flush      (flush),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .done_flush (done_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic a;
    logic b;
    logic busy;
    logic done;
    logic dflush;
    logic ph;
  } exp_t;

  localparam exp_t IdleE = '{a: 1'b0, b: 1'b0, busy: 1'b0, done: 1'b0, dflush: 1'b0, ph: 1'b0};

  exp_t q[$];
  exp_t cur;
  int   n_checks;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_n(input logic pa, input logic pb, input int n, input logic ph);
    exp_t e;
    e = '{a: pa, b: pb, busy: 1'b1, done: 1'b0, dflush: 1'b0, ph: ph};
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic push_gap_done(input logic fl);
    exp_t e;
    push_n(1'b0, 1'b0, MIN_GAP, 1'b0);
    e = '{a: 1'b0, b: 1'b0, busy: 1'b1, done: 1'b1, dflush: fl, ph: 1'b0};
    q.push_back(e);
  endtask

  // Waveform table: ENTER 10,11,01; EXIT 01,11,10; balks only the first phase.
  task automatic build(input logic [1:0] c, input logic [DWELL_W-1:0] dw);
    int d;
    d = (dw == 0) ? 1 : int'(dw);
    case (c)
      2'd0: begin push_n(1, 0, d, 1); push_n(1, 1, d, 1); push_n(0, 1, d, 1); end
      2'd1: begin push_n(0, 1, d, 1); push_n(1, 1, d, 1); push_n(1, 0, d, 1); end
      2'd2: push_n(1, 0, d, 1);
      default: push_n(0, 1, d, 1);
    endcase
    push_gap_done(1'b0);
  endtask

  task automatic model_edge();
    if (!cur.busy) begin
      if (cmd_valid && !flush) build(cmd, dwell);
    end else if (flush && cur.ph) begin
      q.delete();
      push_gap_done(1'b1);
    end
    if (q.size() > 0) cur = q.pop_front();
    else cur = IdleE;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("cycle", {26'd0, a, b, busy, done, done_flush, cmd_ready},
          {26'd0, cur.a, cur.b, cur.busy, cur.done, cur.dflush, !cur.busy});
  endtask

  // Issue one command, then idle until done; returns cycles from accept to done.
  task automatic run_cmd(input logic [1:0] c, input logic [DWELL_W-1:0] dw, output int lat);
    cmd_valid = 1'b1;
    cmd       = c;
    dwell     = dw;
    step();
    cmd_valid = 1'b0;
    lat       = 1;
    while ((done !== 1'b1) && (lat < 2000)) begin
      cmd   = 2'($urandom);
      dwell = DWELL_W'($urandom);
      step();
      lat++;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while ((done !== 1'b1) && (lat < 2000)) begin
      step();
      lat++;
    end
  endtask

  int lat;
  int gap_n;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    q.delete();
    cur       = IdleE;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 2'd0;
    dwell     = '0;
    flush     = 1'b0;
    #2;
    check("reset", {26'd0, a, b, busy, done, done_flush, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // 1: ENTER dwell 3
    run_cmd(2'd0, 8'd3, lat);
    check("lat_enter3", lat, 3 * 3 + MIN_GAP + 1);
    step();

    // 2: EXIT dwell 1
    run_cmd(2'd1, 8'd1, lat);
    check("lat_exit1", lat, 3 * 1 + MIN_GAP + 1);
    step();

    // 3: BALK_ENTER dwell 0
    run_cmd(2'd2, 8'd0, lat);
    check("lat_balk0", lat, 1 + MIN_GAP + 1);
    step();

    // 4: ENTER dwell 4, flush in 2nd cycle of PH2
    cmd_valid = 1'b1; cmd = 2'd0; dwell = 8'd4;
    step();
    cmd_valid = 1'b0;
    repeat (5) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ab", {a, b}, 2'b00);
    lat = 1;
    while ((done !== 1'b1) && (lat < 50)) begin step(); lat++; end
    check("lat_flush", lat, MIN_GAP + 1);
    check("flush_qual", done_flush, 1'b1);
    step();

    // Flush in IDLE blocks the handshake
    cmd_valid = 1'b1; flush = 1'b1; cmd = 2'd1; dwell = 8'd2;
    step();
    check("idle_flush_noaccept", busy, 1'b0);
    cmd_valid = 1'b0; flush = 1'b0;
    step();

    // 5: async reset in PH3 of EXIT dwell 2
    cmd_valid = 1'b1; cmd = 2'd1; dwell = 8'd2;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    check("rst_mid", {26'd0, a, b, busy, done, done_flush, cmd_ready}, 32'h1);
    #2 reset = 1'b0;
    q.delete();
    cur = IdleE;
    run_cmd(2'd0, 8'd2, lat);
    check("lat_after_rst", lat, 3 * 2 + MIN_GAP + 1);
    step();

    // 6: valid held high, ENTER then EXIT queued
    cmd_valid = 1'b1; cmd = 2'd0; dwell = 8'd1;
    step();
    cmd = 2'd1;
    wait_done(lat);
    gap_n = 0;
    while (((a | b) !== 1'b1) && (gap_n < 50)) begin step(); gap_n++; end
    check("b2b_idle_gap", gap_n, 2);
    cmd_valid = 1'b0;
    wait_done(lat);
    step();

    // Max dwell, no wrap
    run_cmd(2'd1, 8'd255, lat);
    check("lat_dwell_max", lat, 3 * 255 + MIN_GAP + 1);
    step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd       = 2'($urandom);
      dwell     = ($urandom_range(0, 15) == 0) ? DWELL_W'($urandom_range(0, 40))
                                               : DWELL_W'($urandom_range(0, 4));
      flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    cmd_valid = 1'b0;
    flush     = 1'b0;
    repeat (200) step();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
